multiplexor_displays: RTL and testbench

Time-multiplexed scanner for a bank of common-anode seven-segment displays. Holds a multi-digit binary value in a shadow register and, at a fixed refresh rate, cycles through the digits, presenting one 4-bit nibble at a time together with that digit's anode enable. It sits directly upstream of the binary-to-hexadecimal segment decoder: `Binario` feeds the decoder input, and the decoder's 7-bit `Hexadecimal` output drives the shared segment lines.

---
 rtl/multiplexor_displays_if.sv | 24 ++
 rtl/multiplexor_displays.sv | 85 ++++++++
 tb/tb_multiplexor_displays.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplexor_displays_if.sv
// Bus between the digit-value source and the seven-segment scanner.
// master drives value/strobes; slave (the scanner) drives the display lines.
interface multiplexor_displays_if #(
  parameter int DIGITOS = 4
);
  localparam int IW = $clog2(DIGITOS);

  logic [4*DIGITOS-1:0] Dato;
  logic                 Cargar;
  logic                 Habilitar;
  logic [3:0]           Binario;
  logic [DIGITOS-1:0]   Anodos;
  logic [IW-1:0]        Indice;

  modport master (
    output Dato, Cargar, Habilitar,
    input  Binario, Anodos, Indice
  );

  modport slave (
    input  Dato, Cargar, Habilitar,
    output Binario, Anodos, Indice
  );
endinterface

// File: rtl/multiplexor_displays.sv
// Time-multiplexed scanner for common-anode seven-segment displays, all outputs registered.
// Optional leading-zero blanking is built only when BLANQUEO_CEROS_EN is defined.
module multiplexor_displays #(
  parameter int DIGITOS = 4,
  parameter int DIV     = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multiplexor_displays_if.slave bus
);
  localparam int IW = $clog2(DIGITOS);
  localparam int PW = $clog2(DIV);
  localparam int W  = 4 * DIGITOS;

  logic [W-1:0]       sombra_q, sombra_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [3:0]         binario_q, binario_d;
  logic [DIGITOS-1:0] anodos_q, anodos_d;
  logic [IW-1:0]      indice_q, indice_d;

  // Handshake: Cargar is a level-sampled strobe; Dato is captured on every edge it is 1.
  // Habilitar gates the scan (prescaler and digit counter) but never the load.

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sombra_q  <= '0;
      pre_q     <= '0;
      idx_q     <= '0;
      binario_q <= '0;
      anodos_q  <= '1;
      indice_q  <= '0;
    end else begin
      sombra_q  <= sombra_d;
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      binario_q <= binario_d;
      anodos_q  <= anodos_d;
      indice_q  <= indice_d;
    end
  end

  always_comb begin
    sombra_d = bus.Cargar ? bus.Dato : sombra_q;
    pre_d    = pre_q;
    idx_d    = idx_q;
    if (bus.Habilitar) begin
      if (pre_q == PW'(DIV - 1)) begin
        pre_d = '0;
        idx_d = (idx_q == IW'(DIGITOS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

`ifdef BLANQUEO_CEROS_EN
  // nz_above[i] is set when any nibble from i up to the most significant is non-zero.
  logic [DIGITOS-1:0] nz_above;

  always_comb begin
    nz_above = '0;
    nz_above[DIGITOS-1] = |sombra_q[W-1 -: 4];
    for (int i = DIGITOS - 2; i >= 0; i--) begin
      nz_above[i] = nz_above[i+1] | (|sombra_q[4*i +: 4]);
    end
  end
`endif

  // Outputs are computed from the pre-edge idx/sombra/Habilitar, giving one cycle of latency.
  always_comb begin
    indice_d  = idx_q;
    binario_d = sombra_q[4*idx_q +: 4];
    anodos_d  = bus.Habilitar ? ~(DIGITOS'(1) << idx_q) : '1;
`ifdef BLANQUEO_CEROS_EN
    if (idx_q != '0 && !nz_above[idx_q]) begin
      anodos_d = '1;
    end
`endif
  end

  assign bus.Binario = binario_q;
  assign bus.Anodos  = anodos_q;
  assign bus.Indice  = indice_q;
endmodule

// File: tb/tb_multiplexor_displays.sv
// Bench for multiplexor_displays with DIGITOS=4, DIV=4, against an enabled-edge-count model.
module tb_multiplexor_displays;
  localparam int DIGITOS = 4;
  localparam int DIV     = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;

  multiplexor_displays_if #(.DIGITOS(DIGITOS)) bus ();

  multiplexor_displays #(.DIGITOS(DIGITOS), .DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the lit digit is (enabled edges since reset / DIV) mod DIGITOS.
  logic [15:0] m_shadow;
  int          m_t;
  logic [3:0]  exp_bin;
  logic [3:0]  exp_an;
  logic [1:0]  exp_ind;
  logic [3:0]  exp_q[$];

  task automatic model_reset();
    m_shadow = '0;
    m_t      = 0;
    exp_bin  = '0;
    exp_an   = 4'hF;
    exp_ind  = '0;
  endtask

  task automatic advance();
    int d;
    @(posedge clk);
    d       = (m_t / DIV) % DIGITOS;
    exp_ind = 2'(d);
    exp_bin = 4'((m_shadow >> (4 * d)) & 16'hF);
    exp_an  = bus.Habilitar ? ~(4'b0001 << d) : 4'hF;
`ifdef BLANQUEO_CEROS_EN
    if (d > 0 && (m_shadow >> (4 * d)) == 16'h0) exp_an = 4'hF;
`endif
    if (bus.Cargar) m_shadow = bus.Dato;
    if (bus.Habilitar) m_t++;
    #1;
  endtask

  task automatic do_reset();
    bus.Cargar    = 1'b0;
    bus.Habilitar = 1'b0;
    bus.Dato      = '0;
    rst_n         = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load_one(input logic [15:0] v);
    bus.Dato   = v;
    bus.Cargar = 1'b1;
    advance();
    bus.Cargar = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.Habilitar = 1'b1;
    load_one(16'hFFFF);
    repeat (6) advance();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.Anodos !== 4'b1111) $display("FAIL reset_anodos: got %b expected 1111", bus.Anodos);
    else passes++;
    checks++;
    if (bus.Binario !== 4'h0) $display("FAIL reset_binario: got %h expected 0", bus.Binario);
    else passes++;
    checks++;
    if (bus.Indice !== 2'd0) $display("FAIL reset_indice: got %0d expected 0", bus.Indice);
    else passes++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // idx moves to 1 on the 4th enabled edge, so Indice shows 1 from the 5th.
    for (int k = 1; k <= 8; k++) begin
      advance();
      checks++;
      if (bus.Indice !== ((k >= 5) ? 2'd1 : 2'd0))
        $display("FAIL first_advance k=%0d: got %0d expected %0d", k, bus.Indice, (k >= 5) ? 1 : 0);
      else passes++;
    end
  endtask

  task automatic test_scan();
    logic [15:0] v;
    int          d;
    v = 16'h3A5C;
    do_reset();
    bus.Habilitar = 1'b1;
    load_one(v);
    for (int k = 2; k <= 33; k++) exp_q.push_back(4'((v >> (4 * (((k - 1) / DIV) % DIGITOS))) & 16'hF));
    for (int k = 2; k <= 33; k++) begin
      advance();
      d = ((k - 1) / DIV) % DIGITOS;
      checks++;
      if (bus.Binario !== exp_q[0]) $display("FAIL scan_binario k=%0d: got %h expected %h", k, bus.Binario, exp_q[0]);
      else passes++;
      void'(exp_q.pop_front());
      checks++;
      if (bus.Anodos !== ~(4'b0001 << d)) $display("FAIL scan_anodos k=%0d: got %b expected %b", k, bus.Anodos, ~(4'b0001 << d));
      else passes++;
      checks++;
      if (bus.Indice !== exp_ind) $display("FAIL scan_indice k=%0d: got %0d expected %0d", k, bus.Indice, exp_ind);
      else passes++;
    end
  endtask

  task automatic test_pause();
    int lit2;
    int n;
    do_reset();
    bus.Habilitar = 1'b1;
    load_one(16'h3A5C);
    n = 0;
    while (bus.Indice !== 2'd2 && n < 20) begin
      advance();
      n++;
    end
    checks++;
    if (bus.Indice !== 2'd2) $display("FAIL pause_reach_digit2: got %0d expected 2", bus.Indice);
    else passes++;
    lit2 = 1;
    advance();
    if (bus.Anodos === 4'b1011) lit2++;
    bus.Habilitar = 1'b0;
    for (int k = 0; k < 6; k++) begin
      advance();
      checks++;
      if (bus.Anodos !== 4'b1111) $display("FAIL pause_anodos k=%0d: got %b expected 1111", k, bus.Anodos);
      else passes++;
      checks++;
      if (bus.Indice !== 2'd2) $display("FAIL pause_indice k=%0d: got %0d expected 2", k, bus.Indice);
      else passes++;
    end
    bus.Habilitar = 1'b1;
    for (int k = 0; k < 12; k++) begin
      advance();
      if (bus.Anodos === 4'b1011) lit2++;
      checks++;
      if (bus.Anodos !== exp_an || bus.Indice !== exp_ind || bus.Binario !== exp_bin)
        $display("FAIL resume k=%0d: got %b/%0d/%h expected %b/%0d/%h", k, bus.Anodos, bus.Indice, bus.Binario, exp_an, exp_ind, exp_bin);
      else passes++;
    end
    checks++;
    if (lit2 !== DIV) $display("FAIL pause_digit2_lit_cycles: got %0d expected %0d", lit2, DIV);
    else passes++;
  endtask

  task automatic test_reload();
    int n;
    do_reset();
    bus.Habilitar = 1'b1;
    load_one(16'h1234);
    n = 0;
    while (bus.Indice !== 2'd1 && n < 20) begin
      advance();
      n++;
    end
    checks++;
    if (bus.Binario !== 4'h3) $display("FAIL reload_before: got %h expected 3", bus.Binario);
    else passes++;
    load_one(16'hBEEF);
    checks++;
    if (bus.Anodos !== 4'b1101) $display("FAIL reload_anodos1: got %b expected 1101", bus.Anodos);
    else passes++;
    advance();
    checks++;
    if (bus.Binario !== 4'hE) $display("FAIL reload_after: got %h expected e", bus.Binario);
    else passes++;
    checks++;
    if (bus.Anodos !== 4'b1101) $display("FAIL reload_anodos2: got %b expected 1101", bus.Anodos);
    else passes++;
  endtask

  task automatic test_cargar_held();
    do_reset();
    bus.Habilitar = 1'b1;
    bus.Cargar    = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bus.Dato = 16'($urandom);
      advance();
      checks++;
      if (bus.Binario !== exp_bin || bus.Anodos !== exp_an || bus.Indice !== exp_ind)
        $display("FAIL held_load k=%0d: got %h/%b/%0d expected %h/%b/%0d", k, bus.Binario, bus.Anodos, bus.Indice, exp_bin, exp_an, exp_ind);
      else passes++;
    end
    bus.Cargar = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 200; k++) begin
      bus.Habilitar = ($urandom_range(0, 5) != 0);
      bus.Cargar    = ($urandom_range(0, 3) == 0);
      bus.Dato      = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      advance();
      checks++;
      if (bus.Binario !== exp_bin || bus.Anodos !== exp_an || bus.Indice !== exp_ind)
        $display("FAIL random k=%0d: got %h/%b/%0d expected %h/%b/%0d", k, bus.Binario, bus.Anodos, bus.Indice, exp_bin, exp_an, exp_ind);
      else passes++;
    end
    bus.Cargar = 1'b0;
  endtask

`ifdef BLANQUEO_CEROS_EN
  task automatic test_blanking();
    do_reset();
    bus.Habilitar = 1'b1;
    load_one(16'h0050);
    for (int k = 0; k < 16; k++) begin
      advance();
      checks++;
      if (bus.Anodos !== exp_an || bus.Binario !== exp_bin)
        $display("FAIL blank_0050 k=%0d: got %b/%h expected %b/%h", k, bus.Anodos, bus.Binario, exp_an, exp_bin);
      else passes++;
    end
    load_one(16'h0000);
    for (int k = 0; k < 16; k++) begin
      advance();
      checks++;
      if (bus.Anodos !== ((bus.Indice == 2'd0) ? 4'b1110 : 4'b1111))
        $display("FAIL blank_0000 k=%0d: got %b at digit %0d", k, bus.Anodos, bus.Indice);
      else passes++;
    end
  endtask
`endif

  initial begin
    checks = 0;
    passes = 0;
    rst_n  = 1'b0;
    bus.Dato      = '0;
    bus.Cargar    = 1'b0;
    bus.Habilitar = 1'b0;
    model_reset();
    test_reset();
    test_scan();
    test_pause();
    test_reload();
    test_cargar_held();
    test_random();
`ifdef BLANQUEO_CEROS_EN
    test_blanking();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
